// File: rtl/counter_sync_nbits_updown.sv
// Fully synchronous modulo-MODULUS up/down counter with load, wrap/saturate mode and terminal count.
// Optional registered Gray-code output gray_out when COUNTER_GRAY_OUT_EN is defined.
module counter_sync_nbits_updown #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset_ah_in,
  input  logic             en_in,
  input  logic             up_in,
  input  logic             load_in,
  input  logic [WIDTH-1:0] load_val_in,
  output logic [WIDTH-1:0] count_out,
  output logic             tc_out,
  output logic             wrap_out
`ifdef COUNTER_GRAY_OUT_EN
  ,
  output logic [WIDTH-1:0] gray_out
`endif
);

  if (WIDTH < 1 || MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_params
    $error("counter_sync_nbits_updown: illegal WIDTH/MODULUS combination");
  end

  // Range end as a WIDTH-bit constant; wrap is detected by compare, never by rollover.
  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);

  logic             at_top;
  logic             at_bot;
  logic [WIDTH-1:0] count_next;
  logic             wrap_next;

  assign at_top = (count_out == TOP);
  assign at_bot = (count_out == '0);
  assign tc_out = en_in & (up_in ? at_top : at_bot);

  always_comb begin
    count_next = count_out;
    wrap_next  = 1'b0;
    if (load_in) begin
      count_next = (load_val_in > TOP) ? TOP : load_val_in;
    end else if (en_in) begin
      if (up_in) begin
        if (!at_top) begin
          count_next = count_out + WIDTH'(1);
        end else if (SATURATE == 0) begin
          count_next = '0;
          wrap_next  = 1'b1;
        end
      end else begin
        if (!at_bot) begin
          count_next = count_out - WIDTH'(1);
        end else if (SATURATE == 0) begin
          count_next = TOP;
          wrap_next  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_ah_in) begin
      count_out <= '0;
      wrap_out  <= 1'b0;
`ifdef COUNTER_GRAY_OUT_EN
      gray_out  <= '0;
`endif
    end else begin
      count_out <= count_next;
      wrap_out  <= wrap_next;
`ifdef COUNTER_GRAY_OUT_EN
      gray_out  <= count_next ^ (count_next >> 1);
`endif
    end
  end

endmodule
